gzip_frame_packer: RTL and testbench

- Wraps a raw deflate byte stream into a complete gzip member: a 10-byte header, then the deflate payload, then an 8-byte trailer.
- The trailer is CRC32 followed by ISIZE, both little-endian.
- Sits downstream of the stream length/CRC32 stage and the deflate encoder. It consumes the per-stream {length, CRC} result pulse and the compressed byte stream.
- It feeds the byte sink (file writer / UART TX) over a valid/ready handshake.

---
 rtl/gzip_frame_packer.sv | 191 +++++++++++++++++++
 tb/tb_gzip_frame_packer.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gzip_frame_packer.sv
// Wraps a raw deflate byte stream into a gzip member: 10-byte header, payload,
// then CRC32 and ISIZE trailer (little-endian), paired with members through an info FIFO.
module gzip_frame_packer #(
    parameter int         INFO_DEPTH = 4,
    parameter logic [7:0] OS_ID      = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_info_en,
    input  logic [31:0] i_info_len,
    input  logic [31:0] i_info_crc,
    output logic        o_info_ovf,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [7:0]  i_byte,
    input  logic        i_last,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [7:0]  o_byte,
    output logic        o_sos,
    output logic        o_last
);

    localparam int PTR_W = $clog2(INFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(INFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_DATA,
        S_WAIT_INFO,
        S_TRAILER
    } state_t;

    state_t           state, state_n;
    logic [3:0]       hdr_cnt, hdr_cnt_n;
    logic [2:0]       trl_cnt, trl_cnt_n;

    logic [31:0]      len_mem [INFO_DEPTH];
    logic [31:0]      crc_mem [INFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] info_cnt;
    logic             info_push, info_pop, info_empty;

    logic             slot_free;
    logic             ld_en, ld_sos, ld_last;
    logic [7:0]       ld_byte;

    function automatic logic [7:0] header_byte(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h1F;
            4'd1:    return 8'h8B;
            4'd2:    return 8'h08;
            4'd9:    return OS_ID;
            default: return 8'h00;
        endcase
    endfunction

    // Bytes 0-3 come from the CRC word, bytes 4-7 from ISIZE, LSB first.
    function automatic logic [7:0] trailer_byte(input logic [2:0] idx, input logic [31:0] crc,
                                                input logic [31:0] len);
        logic [31:0] word;
        word = idx[2] ? len : crc;
        case (idx[1:0])
            2'd0:    return word[7:0];
            2'd1:    return word[15:8];
            2'd2:    return word[23:16];
            default: return word[31:24];
        endcase
    endfunction

    assign slot_free  = ~o_valid | i_ready;
    assign o_ready    = (state == S_DATA) & slot_free;
    assign info_empty = (info_cnt == '0);
    assign info_push  = i_info_en & ((info_cnt != DEPTH_C) | info_pop);

    always_comb begin
        state_n   = state;
        hdr_cnt_n = hdr_cnt;
        trl_cnt_n = trl_cnt;
        ld_en     = 1'b0;
        ld_byte   = 8'h00;
        ld_sos    = 1'b0;
        ld_last   = 1'b0;
        info_pop  = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_valid) begin
                    state_n   = S_HEADER;
                    hdr_cnt_n = 4'd0;
                end
            end
            S_HEADER: begin
                if (slot_free) begin
                    ld_en   = 1'b1;
                    ld_byte = header_byte(hdr_cnt);
                    ld_sos  = (hdr_cnt == 4'd0);
                    if (hdr_cnt == 4'd9) state_n = S_DATA;
                    else                 hdr_cnt_n = hdr_cnt + 4'd1;
                end
            end
            S_DATA: begin
                if (i_valid && slot_free) begin
                    ld_en   = 1'b1;
                    ld_byte = i_byte;
                    if (i_last) begin
                        trl_cnt_n = 3'd0;
                        state_n   = info_empty ? S_WAIT_INFO : S_TRAILER;
                    end
                end
            end
            S_WAIT_INFO: begin
                if (!info_empty) begin
                    state_n   = S_TRAILER;
                    trl_cnt_n = 3'd0;
                end
            end
            S_TRAILER: begin
                if (slot_free) begin
                    ld_en   = 1'b1;
                    ld_byte = trailer_byte(trl_cnt, crc_mem[rd_ptr], len_mem[rd_ptr]);
                    if (trl_cnt == 3'd7) begin
                        ld_last  = 1'b1;
                        info_pop = 1'b1;
                        state_n  = S_IDLE;
                    end else begin
                        trl_cnt_n = trl_cnt + 3'd1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            hdr_cnt <= 4'd0;
            trl_cnt <= 3'd0;
        end else begin
            state   <= state_n;
            hdr_cnt <= hdr_cnt_n;
            trl_cnt <= trl_cnt_n;
        end
    end

    // Info FIFO control; a full FIFO still takes a push when the head pops this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            info_cnt   <= '0;
            o_info_ovf <= 1'b0;
        end else begin
            if (info_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (info_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({info_push, info_pop})
                2'b10:   info_cnt <= info_cnt + CNT_W'(1);
                2'b01:   info_cnt <= info_cnt - CNT_W'(1);
                default: info_cnt <= info_cnt;
            endcase
            if (i_info_en && !info_push) o_info_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (info_push) begin
            len_mem[wr_ptr] <= i_info_len;
            crc_mem[wr_ptr] <= i_info_crc;
        end
    end

    // Output register stage: loads on a free slot, holds under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_byte  <= 8'h00;
            o_sos   <= 1'b0;
            o_last  <= 1'b0;
        end else if (ld_en) begin
            o_valid <= 1'b1;
            o_byte  <= ld_byte;
            o_sos   <= ld_sos;
            o_last  <= ld_last;
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gzip_frame_packer.sv
// Self-checking bench for gzip_frame_packer: a queue-based member model checks
// every output transfer, with literal byte sequences pinning the model.
module tb_gzip_frame_packer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_info_en = 1'b0;
    logic [31:0] i_info_len = '0;
    logic [31:0] i_info_crc = '0;
    logic        o_info_ovf;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [7:0]  i_byte = '0;
    logic        i_last = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [7:0]  o_byte;
    logic        o_sos;
    logic        o_last;

    gzip_frame_packer #(.INFO_DEPTH(DEPTH), .OS_ID(8'hFF)) dut (
        .clk(clk), .rst(rst),
        .i_info_en(i_info_en), .i_info_len(i_info_len), .i_info_crc(i_info_crc),
        .o_info_ovf(o_info_ovf),
        .i_valid(i_valid), .o_ready(o_ready), .i_byte(i_byte), .i_last(i_last),
        .o_valid(o_valid), .i_ready(i_ready), .o_byte(o_byte), .o_sos(o_sos), .o_last(o_last)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  HDR  [10] = '{8'h1F, 8'h8B, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
    logic [7:0]  EXP1 [21] = '{8'h1F, 8'h8B, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF,
                               8'h4B, 8'h04, 8'h00, 8'h43, 8'hBE, 8'hB7, 8'hE8, 8'h01, 8'h00, 8'h00, 8'h00};
    logic [7:0]  EXP4 [16] = '{8'hC2, 8'h41, 8'h24, 8'h35, 8'h03, 8'h00, 8'h00, 8'h00,
                               8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h04, 8'h03, 8'h02, 8'h01};

    // Model state: pending payload bytes {last, byte} and queued infos {len, crc}.
    logic [8:0]  pay_q [$];
    logic [63:0] info_q [$];
    logic        ovf_exp = 1'b0;
    logic [7:0]  got [$];
    int          got_cyc [$];
    int          members_done = 0;
    int          chk_trl = -1;
    bit          rdy_rand = 1'b0;
    logic [7:0]  pbuf [64];

    int          phase = 0, pos = 0, tpos = 0;
    bit          hold = 1'b0;
    logic [7:0]  hb;
    logic        hs, hl;
    logic [8:0]  pe;
    logic [63:0] ie;
    logic [7:0]  eb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        i_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Compare process: sampled one time unit before each rising edge.
    initial forever begin
        @(negedge clk);
        #4;
        if (rst) begin
            phase = 0; pos = 0; tpos = 0; hold = 1'b0; chk_trl = -1;
            pay_q.delete();
            info_q.delete();
            continue;
        end
        if (hold) begin
            check("hold_valid", 32'(o_valid), 32'd1);
            check("hold_byte", 32'(o_byte), 32'(hb));
            check("hold_sos", 32'(o_sos), 32'(hs));
            check("hold_last", 32'(o_last), 32'(hl));
        end
        hold = o_valid && !i_ready;
        hb = o_byte; hs = o_sos; hl = o_last;
        chk_trl = -1;
        if (o_valid && i_ready) begin
            got.push_back(o_byte);
            got_cyc.push_back(cyc);
            if (phase == 0) begin
                eb = HDR[pos];
                check("hdr_byte", 32'(o_byte), 32'(eb));
                check("hdr_sos", 32'(o_sos), 32'(pos == 0));
                check("hdr_last", 32'(o_last), 32'd0);
                pos++;
                if (pos == 10) phase = 1;
            end else if (phase == 1) begin
                if (pay_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_payload: got byte %0h with no payload pending", o_byte);
                end else begin
                    pe = pay_q.pop_front();
                    check("pay_byte", 32'(o_byte), 32'(pe[7:0]));
                    check("pay_flags", 32'({o_sos, o_last}), 32'd0);
                    if (pe[8]) begin phase = 2; tpos = 0; end
                end
            end else begin
                if (info_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL trailer_info: got byte %0h with no info queued", o_byte);
                    ie = '0;
                end else begin
                    ie = info_q[0];
                end
                eb = (tpos < 4) ? 8'(ie[31:0] >> (8 * tpos)) : 8'(ie[63:32] >> (8 * (tpos - 4)));
                check("trl_byte", 32'(o_byte), 32'(eb));
                check("trl_sos", 32'(o_sos), 32'd0);
                check("trl_last", 32'(o_last), 32'(tpos == 7));
                chk_trl = tpos;
                tpos++;
                if (tpos == 8) begin
                    if (info_q.size() != 0) void'(info_q.pop_front());
                    phase = 0; pos = 0;
                    members_done++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input logic l);
        int n = 0;
        forever begin
            @(negedge clk);
            i_valid = 1'b1; i_byte = b; i_last = l;
            #4;
            if (o_ready) begin
                pay_q.push_back({l, b});
                break;
            end
            n++;
            if (n > 300) begin
                checks++; errors++;
                $display("FAIL send_timeout: o_ready never rose for byte %0h", b);
                break;
            end
        end
    endtask

    task automatic send_member(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(negedge clk);
                i_valid = 1'b0;
            end
            send_byte(pbuf[i], i == n - 1);
        end
        @(negedge clk);
        i_valid = 1'b0; i_last = 1'b0;
    endtask

    task automatic model_push(input logic [31:0] len, input logic [31:0] crc, input bit with_pop);
        if (with_pop || info_q.size() < DEPTH) info_q.push_back({len, crc});
        else ovf_exp = 1'b1;
    endtask

    task automatic pulse_info(input logic [31:0] len, input logic [31:0] crc);
        @(negedge clk);
        i_info_en = 1'b1; i_info_len = len; i_info_crc = crc;
        model_push(len, crc, 1'b0);
        @(negedge clk);
        i_info_en = 1'b0;
        #4;
        check("info_ovf", 32'(o_info_ovf), 32'(ovf_exp));
    endtask

    task automatic wait_members(input int target);
        int n = 0;
        while (members_done < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("members_done", 32'(members_done), 32'(target));
        repeat (2) @(negedge clk);
    endtask

    task automatic check_exp1(input string name);
        check({name, "_len"}, 32'(got.size()), 32'd21);
        for (int i = 0; i < 21 && i < got.size(); i++)
            check(name, 32'(got[i]), 32'(EXP1[i]));
    endtask

    task automatic load_exp1_payload();
        pbuf[0] = 8'h4B; pbuf[1] = 8'h04; pbuf[2] = 8'h00;
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) pbuf[i] = 8'($urandom);
    endtask

    task automatic reset_outputs_zero(input string name);
        check({name, "_valid"}, 32'(o_valid), 32'd0);
        check({name, "_byte"}, 32'(o_byte), 32'd0);
        check({name, "_sos"}, 32'(o_sos), 32'd0);
        check({name, "_last"}, 32'(o_last), 32'd0);
        check({name, "_ready"}, 32'(o_ready), 32'd0);
        check({name, "_ovf"}, 32'(o_info_ovf), 32'd0);
    endtask

    initial begin
        int done;
        int plen;
        int n;
        repeat (2) @(negedge clk);
        #2;
        reset_outputs_zero("reset");
        rst = 1'b0;

        // Single member, sink always ready, info first.
        got.delete(); got_cyc.delete();
        pulse_info(32'd1, 32'hE8B7BE43);
        load_exp1_payload();
        send_member(3, 1'b0);
        wait_members(1);
        check_exp1("single");
        if (got_cyc.size() == 21) check("single_no_gap", 32'(got_cyc[20] - got_cyc[0]), 32'd20);

        // Info arrives 20 cycles after the last deflate byte.
        got.delete();
        load_exp1_payload();
        send_member(3, 1'b0);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk); #4;
            check("wait_info_idle", 32'(o_valid), 32'd0);
        end
        pulse_info(32'd1, 32'hE8B7BE43);
        wait_members(2);
        check_exp1("late_info");

        // Random backpressure on the sink plus input gaps.
        rdy_rand = 1'b1;
        got.delete();
        pulse_info(32'd1, 32'hE8B7BE43);
        load_exp1_payload();
        send_member(3, 1'b1);
        wait_members(3);
        check_exp1("backpressure");
        rdy_rand = 1'b0;

        // Two back-to-back members with both infos queued up front.
        got.delete();
        pulse_info(32'd3, 32'h352441C2);
        pulse_info(32'h01020304, 32'hDEADBEEF);
        fill_random(3);
        send_member(3, 1'b0);
        fill_random(2);
        send_member(2, 1'b0);
        wait_members(5);
        check("b2b_len", 32'(got.size()), 32'd41);
        if (got.size() == 41) begin
            for (int i = 0; i < 8; i++) check("b2b_trl1", 32'(got[13 + i]), 32'(EXP4[i]));
            for (int i = 0; i < 8; i++) check("b2b_trl2", 32'(got[33 + i]), 32'(EXP4[8 + i]));
        end

        // Full FIFO: a push landing in the same cycle as the pop is accepted.
        for (int i = 0; i < DEPTH; i++) pulse_info($urandom, $urandom);
        fill_random(2);
        fork
            send_member(2, 1'b0);
            begin
                n = 0;
                do begin
                    @(negedge clk); #2;
                    n++;
                end while (chk_trl != 5 && n < 500);
                check("pop_sync_found", 32'(chk_trl), 32'd5);
                i_info_en = 1'b1; i_info_len = 32'h0BADF00D; i_info_crc = 32'h12345678;
                model_push(32'h0BADF00D, 32'h12345678, 1'b1);
                @(negedge clk);
                i_info_en = 1'b0;
                #4;
                check("push_on_pop_ovf", 32'(o_info_ovf), 32'd0);
            end
        join
        done = 6;
        for (int m = 0; m < DEPTH; m++) begin
            plen = (m == 0) ? 1 : $urandom_range(1, 5);
            fill_random(plen);
            send_member(plen, 1'b0);
        end
        done += DEPTH;
        wait_members(done);

        // Overflow: one more pulse than the FIFO holds, then drain the kept entries.
        for (int i = 0; i <= DEPTH; i++) pulse_info($urandom, $urandom);
        check("ovf_set", 32'(o_info_ovf), 32'd1);
        rdy_rand = 1'b1;
        for (int m = 0; m < DEPTH; m++) begin
            plen = $urandom_range(1, 4);
            fill_random(plen);
            send_member(plen, 1'b1);
        end
        done += DEPTH;
        wait_members(done);
        check("ovf_sticky", 32'(o_info_ovf), 32'd1);

        // Randomized members, info before or after the data.
        for (int m = 0; m < 6; m++) begin
            plen = $urandom_range(1, 8);
            fill_random(plen);
            if ($urandom_range(0, 1) == 1) begin
                pulse_info($urandom, $urandom);
                send_member(plen, 1'b1);
            end else begin
                send_member(plen, 1'b1);
                repeat ($urandom_range(0, 6)) @(negedge clk);
                pulse_info($urandom, $urandom);
            end
        end
        done += 6;
        wait_members(done);
        rdy_rand = 1'b0;

        // Reset in the middle of the payload, then a fresh member.
        pulse_info(32'd7, 32'hCAFEBABE);
        for (int i = 0; i < 3; i++) send_byte(8'(8'h10 + i), 1'b0);
        @(negedge clk);
        i_valid = 1'b0;
        #2;
        rst = 1'b1;
        ovf_exp = 1'b0;
        #1;
        reset_outputs_zero("mid_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        got.delete();
        pulse_info(32'd1, 32'hE8B7BE43);
        load_exp1_payload();
        send_member(3, 1'b0);
        wait_members(done + 1);
        check_exp1("after_reset");

        check("end_payload_empty", 32'(pay_q.size()), 32'd0);
        check("end_info_empty", 32'(info_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
